rotor_step_controller: RTL and testbench
========================================

Name: rotor_step_controller

Overview:
- Per-character sequencer for the ENIGMA551 cipher path.
- Accepts plaintext letters on a valid/ready handshake and advances the three rotor positions using Enigma stepping rules, including notch turnover and double-stepping.
- Drives the positions to the rotor datapath, launches one encode, and waits for its done strobe.
- Returns the cipher letter on an output valid/ready handshake. Replaces free-running, level-triggered position counting with a clocked, single-owner scheduler.

Parameters:
- ALPHA, 26, alphabet size; legal letter/position codes are 0..ALPHA-1.
- NOTCH1, 21, rotor1 (fast) turnover position ('V').
- NOTCH2, 4, rotor2 (middle) turnover position ('E').
- TIMEOUT, 255, maximum WAIT cycles before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  load start positions (IDLE only).
- cfg_pos1 / cfg_pos2 / cfg_pos3  in  5 each  start positions.
- in_valid  in  1  plaintext letter valid.
- in_ready  out  1  controller can accept a letter.
- in_char  in  5  plaintext letter code.
- enc_start  out  1  one-cycle launch pulse to the datapath.
- enc_char  out  5  letter presented to the datapath.
- rotor1_pos / rotor2_pos / rotor3_pos  out  5 each  current rotor positions.
- enc_done  in  1  datapath result strobe.
- enc_result  in  5  datapath cipher letter.
- out_valid  out  1  cipher letter valid.
- out_ready  in  1  consumer accepts the letter.
- out_char  out  5  cipher letter.
- err  out  1  one-cycle error pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all positions, enc_char, out_char = 0; in_ready, enc_start, out_valid, err, busy = 0. in_ready rises on the first clock edge after release.
- States: IDLE -> STEP -> ISSUE -> WAIT -> OUT -> IDLE.
- IDLE:
  - in_ready=1 except in a cycle where cfg_load=1.
  - cfg_load has priority over in_valid. If any cfg_pos > 25: pulse err, positions unchanged. Otherwise load all three positions next edge and stay in IDLE.
  - cfg_load outside IDLE is ignored (no err).
  - Handshake in_valid&in_ready with in_char<=25: latch in_char into enc_char, go to STEP.
  - Handshake with in_char>25: pulse err, drop the letter, no stepping, stay in IDLE.
- STEP (1 cycle): evaluate all conditions from pre-step positions, update on the same edge.
  - p1 <= p1+1.
  - p2 <= p2+1 if p1==NOTCH1 or p2==NOTCH2 (double-step).
  - p3 <= p3+1 if p2==NOTCH2.
  - All increments wrap 25->0 (mod ALPHA, never 26..31). No carry out of rotor3.
- ISSUE (1 cycle): enc_start=1. Positions and enc_char are stable from ISSUE until WAIT exits.
- WAIT:
  - On enc_done: latch enc_result into out_char, go to OUT.
  - Timeout counter (8 bit) counts from 0 on entry. If TIMEOUT cycles elapse without enc_done: pulse err, return to IDLE, positions keep their stepped values.
  - enc_done in any other state is ignored.
- OUT: out_valid=1, out_char held until out_ready is sampled high, then go to IDLE. No combinational in->out path.
- Minimum letter-to-letter throughput: 5 cycles, with enc_done arriving one cycle after enc_start and out_ready high.
- in_ready=0 whenever busy=1, so a second letter cannot be accepted mid-operation.
- Rotor positions change only in STEP, on cfg_load, or on reset.

Decomposition:
- Shared package enigma_pkg: ALPHA, letter width (5), default notch constants, state enum encoding (IDLE/STEP/ISSUE/WAIT/OUT).
- One natural sub-module: rotor_stepper. It is combinational next-position logic from (p1,p2,p3,NOTCH1,NOTCH2) with mod-26 wrap, reused by the TB reference model.

Test Plan:
- Reset, then in_char=0 with enc_done 1 cycle after enc_start -> positions (1,0,0); out_char=enc_result; busy low after out handshake.
- cfg_load (21,0,0), one letter -> positions (22,1,0); rotor3 unchanged.
- Double-step: cfg_load (20,3,0), three letters -> (21,3,0), (22,4,0), (23,5,1).
- Wrap: cfg_load (25,25,25), one letter -> (0,25,25); cfg_load (26,0,0) -> err pulse, positions unchanged. in_char=27 -> err, no step, in_ready stays 1.
- Backpressure/timeout: hold out_ready=0 for 10 cycles -> out_valid and out_char stable, in_ready=0. Withhold enc_done -> err after 255 WAIT cycles, state returns to IDLE with positions stepped.
- Assert rst low during WAIT -> outputs zero immediately (asynchronous). A late enc_done after release is ignored; the next letter steps from (0,0,0) to (1,0,0).

Source files
------------

// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, types and helpers for the rotor step controller
package enigma_pkg;

    localparam int ALPHA = 26;
    localparam int LW    = 5;

    typedef logic [LW-1:0] letter_t;

    localparam letter_t    LAST_POS    = letter_t'(ALPHA - 1);
    localparam letter_t    NOTCH1_DEF  = 5'd21;
    localparam letter_t    NOTCH2_DEF  = 5'd4;
    localparam logic [7:0] TIMEOUT_DEF = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    // Advance one position with wrap at the end of the alphabet.
    function automatic letter_t inc_mod(input letter_t p);
        return (p >= LAST_POS) ? '0 : p + 5'd1;
    endfunction

endpackage

// File: rtl/rotor_step_controller_if.sv
// rtl/rotor_step_controller_if.sv - letter, config and datapath handshake bundle
interface rotor_step_controller_if;
    import enigma_pkg::*;

    logic    cfg_load;
    letter_t cfg_pos1;
    letter_t cfg_pos2;
    letter_t cfg_pos3;
    logic    in_valid;
    logic    in_ready;
    letter_t in_char;
    logic    enc_start;
    letter_t enc_char;
    letter_t rotor1_pos;
    letter_t rotor2_pos;
    letter_t rotor3_pos;
    logic    enc_done;
    letter_t enc_result;
    logic    out_valid;
    logic    out_ready;
    letter_t out_char;
    logic    err;
    logic    busy;

    modport slave (
        input  cfg_load, cfg_pos1, cfg_pos2, cfg_pos3,
        input  in_valid, in_char, enc_done, enc_result, out_ready,
        output in_ready, enc_start, enc_char,
        output rotor1_pos, rotor2_pos, rotor3_pos,
        output out_valid, out_char, err, busy
    );

    modport master (
        output cfg_load, cfg_pos1, cfg_pos2, cfg_pos3,
        output in_valid, in_char, enc_done, enc_result, out_ready,
        input  in_ready, enc_start, enc_char,
        input  rotor1_pos, rotor2_pos, rotor3_pos,
        input  out_valid, out_char, err, busy
    );

endinterface

// File: rtl/rotor_stepper.sv
// rtl/rotor_stepper.sv - next rotor positions with notch turnover and double-stepping
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter letter_t NOTCH1 = NOTCH1_DEF,
    parameter letter_t NOTCH2 = NOTCH2_DEF
) (
    input  letter_t p1,
    input  letter_t p2,
    input  letter_t p3,
    output letter_t n1,
    output letter_t n2,
    output letter_t n3
);

    logic turn1;
    logic turn2;

    assign turn1 = (p1 == NOTCH1);
    assign turn2 = (p2 == NOTCH2);

    // The middle rotor also steps itself when it sits on its own notch.
    assign n1 = inc_mod(p1);
    assign n2 = (turn1 || turn2) ? inc_mod(p2) : p2;
    assign n3 = turn2 ? inc_mod(p3) : p3;

endmodule

// File: rtl/rotor_step_controller.sv
// rtl/rotor_step_controller.sv - per-letter rotor stepping and encode sequencing
module rotor_step_controller
    import enigma_pkg::*;
#(
    parameter letter_t    NOTCH1  = NOTCH1_DEF,
    parameter letter_t    NOTCH2  = NOTCH2_DEF,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    rotor_step_controller_if.slave bus
);

    state_t     state;
    letter_t    p1, p2, p3;
    letter_t    n1, n2, n3;
    letter_t    enc_char_q;
    letter_t    out_char_q;
    logic       rdy_q;
    logic       start_q;
    logic       valid_q;
    logic       err_q;
    logic       busy_q;
    logic [7:0] wait_cnt;
    logic       cfg_bad;
    logic       char_bad;

    rotor_stepper #(
        .NOTCH1 (NOTCH1),
        .NOTCH2 (NOTCH2)
    ) u_stepper (
        .p1 (p1),
        .p2 (p2),
        .p3 (p3),
        .n1 (n1),
        .n2 (n2),
        .n3 (n3)
    );

    assign cfg_bad  = (bus.cfg_pos1 > LAST_POS) || (bus.cfg_pos2 > LAST_POS) ||
                      (bus.cfg_pos3 > LAST_POS);
    assign char_bad = (bus.in_char > LAST_POS);

    // A config load owns the IDLE cycle, so no letter may be taken alongside it.
    assign bus.in_ready   = rdy_q & ~bus.cfg_load;
    assign bus.enc_start  = start_q;
    assign bus.enc_char   = enc_char_q;
    assign bus.rotor1_pos = p1;
    assign bus.rotor2_pos = p2;
    assign bus.rotor3_pos = p3;
    assign bus.out_valid  = valid_q;
    assign bus.out_char   = out_char_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p1         <= '0;
            p2         <= '0;
            p3         <= '0;
            enc_char_q <= '0;
            out_char_q <= '0;
            rdy_q      <= 1'b0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.cfg_load) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            p1 <= bus.cfg_pos1;
                            p2 <= bus.cfg_pos2;
                            p3 <= bus.cfg_pos3;
                        end
                    end else if (bus.in_valid && rdy_q) begin
                        if (char_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            enc_char_q <= bus.in_char;
                            rdy_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            state      <= STEP;
                        end
                    end
                end
                STEP: begin
                    p1      <= n1;
                    p2      <= n2;
                    p3      <= n3;
                    start_q <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.enc_done) begin
                        out_char_q <= bus.enc_result;
                        valid_q    <= 1'b1;
                        state      <= OUT;
                    end else if (wait_cnt == TIMEOUT - 8'd1) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_step_controller.sv
// tb/tb_rotor_step_controller.sv - directed vector bench for rotor_step_controller
module tb_rotor_step_controller;
    import enigma_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    rotor_step_controller_if bus();

    rotor_step_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit load;
        int c1, c2, c3;
        int ch;
        int res;
        int e1, e2, e3;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [14:0] pk(input int a, input int b, input int c);
        return {a[4:0], b[4:0], c[4:0]};
    endfunction

    function automatic logic [14:0] cur_pos();
        return {bus.rotor1_pos, bus.rotor2_pos, bus.rotor3_pos};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic do_cfg(input string tag, input int a, input int b, input int c,
                          input bit exp_err, input logic [14:0] exp_pos);
        bus.cfg_load = 1'b1;
        bus.cfg_pos1 = 5'(a);
        bus.cfg_pos2 = 5'(b);
        bus.cfg_pos3 = 5'(c);
        #1 check({tag, "_in_ready_low"}, bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_pos"}, cur_pos(), exp_pos);
    endtask

    task automatic send_letter(input string tag, input int ch, input int res,
                               input logic [14:0] exp_pos);
        int n;
        int t_acc;
        bus.in_valid = 1'b1;
        bus.in_char  = 5'(ch);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        t_acc = cyc;
        check({tag, "_busy"}, bus.busy, 1);
        n = 0;
        while (!bus.enc_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, bus.enc_start, 1);
        if (!bus.enc_start) return;
        check({tag, "_enc_char"}, bus.enc_char, ch);
        check({tag, "_pos_issue"}, cur_pos(), exp_pos);
        @(negedge clk);
        check({tag, "_start_pulse"}, bus.enc_start, 0);
        bus.enc_done   = 1'b1;
        bus.enc_result = 5'(res);
        @(negedge clk);
        bus.enc_done = 1'b0;
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_out_char"}, bus.out_char, res);
        @(negedge clk);
        check({tag, "_idle"}, {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        check({tag, "_pos_final"}, cur_pos(), exp_pos);
        check({tag, "_interval"}, cyc + 1 - t_acc, 5);
    endtask

    initial begin
        int n;
        bus.cfg_load   = 1'b0;
        bus.cfg_pos1   = '0;
        bus.cfg_pos2   = '0;
        bus.cfg_pos3   = '0;
        bus.in_valid   = 1'b0;
        bus.in_char    = '0;
        bus.enc_done   = 1'b0;
        bus.enc_result = '0;
        bus.out_ready  = 1'b1;

        vecs[0] = '{0,  0,  0,  0,  0,  7,  1,  0,  0};
        vecs[1] = '{1, 21,  0,  0,  3, 12, 22,  1,  0};
        vecs[2] = '{1, 20,  3,  0,  1,  5, 21,  3,  0};
        vecs[3] = '{0,  0,  0,  0,  2,  9, 22,  4,  0};
        vecs[4] = '{0,  0,  0,  0, 25,  0, 23,  5,  1};
        vecs[5] = '{1, 25, 25, 25,  4, 25,  0, 25, 25};
        vecs[6] = '{1,  3,  4, 25, 10, 11,  4,  5,  0};
        vecs[7] = '{1, 21, 25,  7,  6, 14, 22,  0,  7};

        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", {bus.in_ready, bus.enc_start, bus.out_valid, bus.err, bus.busy}, 0);
        check("rst_pos", cur_pos(), 0);
        check("rst_chars", {bus.enc_char, bus.out_char}, 0);
        rst_n = 1'b1;
        #1 check("rst_release_ready", bus.in_ready, 0);
        @(negedge clk);
        check("ready_after_release", bus.in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].load)
                do_cfg($sformatf("v%0d_cfg", i), vecs[i].c1, vecs[i].c2, vecs[i].c3, 1'b0,
                       pk(vecs[i].c1, vecs[i].c2, vecs[i].c3));
            send_letter($sformatf("v%0d", i), vecs[i].ch, vecs[i].res,
                        pk(vecs[i].e1, vecs[i].e2, vecs[i].e3));
        end

        do_cfg("cfg_bad", 26, 0, 0, 1'b1, pk(22, 0, 7));
        @(negedge clk);
        check("cfg_bad_err_pulse", bus.err, 0);

        bus.in_valid = 1'b1;
        bus.in_char  = 5'd27;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("char_bad_err", bus.err, 1);
        check("char_bad_state", {bus.busy, bus.in_ready}, 2'b01);
        check("char_bad_pos", cur_pos(), pk(22, 0, 7));

        // Backpressure with a stray config load while busy.
        bus.in_valid = 1'b1;
        bus.in_char  = 5'd11;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.enc_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("bp_start", bus.enc_start, 1);
        @(negedge clk);
        bus.enc_done   = 1'b1;
        bus.enc_result = 5'd19;
        bus.out_ready  = 1'b0;
        bus.cfg_load   = 1'b1;
        bus.cfg_pos1   = 5'd1;
        bus.cfg_pos2   = 5'd1;
        bus.cfg_pos3   = 5'd1;
        @(negedge clk);
        bus.enc_done   = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.enc_result = 5'd3;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i),
                  {bus.out_valid, bus.out_char, bus.in_ready, bus.err}, {1'b1, 5'd19, 1'b0, 1'b0});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {bus.out_valid, bus.busy}, 2'b00);
        check("bp_pos", cur_pos(), pk(23, 0, 7));

        // Both turnover conditions at once, then no enc_done.
        do_cfg("to_cfg", 21, 4, 9, 1'b0, pk(21, 4, 9));
        bus.in_valid = 1'b1;
        bus.in_char  = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.enc_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("to_start", bus.enc_start, 1);
        n = 0;
        while (!bus.err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, 256);
        check("to_state", {bus.busy, bus.in_ready, bus.out_valid}, 3'b010);
        check("to_pos", cur_pos(), pk(22, 5, 10));

        // Asynchronous reset while waiting, then a late done strobe.
        bus.in_valid = 1'b1;
        bus.in_char  = 5'd0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.enc_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_outputs", {bus.in_ready, bus.out_valid, bus.err, bus.busy, bus.enc_start}, 0);
        check("arst_pos", cur_pos(), 0);
        check("arst_chars", {bus.enc_char, bus.out_char}, 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.enc_done   = 1'b1;
        bus.enc_result = 5'd9;
        @(negedge clk);
        bus.enc_done = 1'b0;
        check("late_done_ignored", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        send_letter("post_rst", 5, 6, pk(1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
